// File: rtl/instr_encoder_pkg.sv
// Shared MIPS encoding definitions: opcode constants, op_sel encoding,
// instruction field bit positions, encoder FSM states and word-packing helpers.
package instr_encoder_pkg;

    // Primary 6-bit opcodes (shared with the CPU opcode decoder)
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_BLEZ  = 6'b000110;
    localparam logic [5:0] OPC_BGTZ  = 6'b000111;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    // Field bit positions within a 32-bit instruction word
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int TGT_MSB = 25;

    // op_sel encoding; values 14 and 15 are illegal
    typedef enum logic [3:0] {
        SEL_R     = 4'd0,
        SEL_ADDI  = 4'd1,
        SEL_BEQ   = 4'd2,
        SEL_BNE   = 4'd3,
        SEL_LUI   = 4'd4,
        SEL_ORI   = 4'd5,
        SEL_SLTIU = 4'd6,
        SEL_J     = 4'd7,
        SEL_JAL   = 4'd8,
        SEL_BLEZ  = 4'd9,
        SEL_BGTZ  = 4'd10,
        SEL_LW    = 4'd11,
        SEL_SW    = 4'd12,
        SEL_LI    = 4'd13
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LI2  = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        logic [31:0] w;
        w                 = '0;
        w[OP_MSB:OP_LSB]  = OPC_RTYPE;
        w[RS_MSB:RS_LSB]  = rs;
        w[RT_MSB:RT_LSB]  = rt;
        w[RD_MSB:RD_LSB]  = rd;
        w[SH_MSB:SH_LSB]  = shamt;
        w[FN_MSB:FN_LSB]  = funct;
        return w;
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        logic [31:0] w;
        w                 = '0;
        w[OP_MSB:OP_LSB]  = opc;
        w[RS_MSB:RS_LSB]  = rs;
        w[RT_MSB:RT_LSB]  = rt;
        w[IMM_MSB:0]      = imm;
        return w;
    endfunction

    function automatic logic [31:0] pack_j(input logic [5:0] opc, input logic [25:0] target);
        logic [31:0] w;
        w                 = '0;
        w[OP_MSB:OP_LSB]  = opc;
        w[TGT_MSB:0]      = target;
        return w;
    endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packing of an op_sel request into one 32-bit MIPS word.
// Ports: op_sel_i, rs_i/rt_i/rd_i/shamt_i, funct_i, imm_i request fields;
//        li_phase_i selects the li half (0: lui rt,imm[31:16]; 1: ori rt,rt,imm[15:0]);
//        word_o encoded word, illegal_o set for op_sel 14/15.
module instr_word_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  op_sel_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] imm_i,
    input  logic        li_phase_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_sel_i)
            SEL_R:     word_o = pack_r(rs_i, rt_i, rd_i, shamt_i, funct_i);
            SEL_ADDI:  word_o = pack_i(OPC_ADDI,  rs_i, rt_i, imm_i[15:0]);
            SEL_BEQ:   word_o = pack_i(OPC_BEQ,   rs_i, rt_i, imm_i[15:0]);
            SEL_BNE:   word_o = pack_i(OPC_BNE,   rs_i, rt_i, imm_i[15:0]);
            SEL_LUI:   word_o = pack_i(OPC_LUI,   5'd0, rt_i, imm_i[15:0]);
            SEL_ORI:   word_o = pack_i(OPC_ORI,   rs_i, rt_i, imm_i[15:0]);
            SEL_SLTIU: word_o = pack_i(OPC_SLTIU, rs_i, rt_i, imm_i[15:0]);
            SEL_J:     word_o = pack_j(OPC_J,   imm_i[25:0]);
            SEL_JAL:   word_o = pack_j(OPC_JAL, imm_i[25:0]);
            SEL_BLEZ:  word_o = pack_i(OPC_BLEZ, rs_i, 5'd0, imm_i[15:0]);
            SEL_BGTZ:  word_o = pack_i(OPC_BGTZ, rs_i, 5'd0, imm_i[15:0]);
            SEL_LW:    word_o = pack_i(OPC_LW,    rs_i, rt_i, imm_i[15:0]);
            SEL_SW:    word_o = pack_i(OPC_SW,    rs_i, rt_i, imm_i[15:0]);
            SEL_LI: begin
                if (li_phase_i) word_o = pack_i(OPC_ORI, rt_i, rt_i, imm_i[15:0]);
                else            word_o = pack_i(OPC_LUI, 5'd0, rt_i, imm_i[31:16]);
            end
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into MIPS words and writes them sequentially
// into instruction memory from BASE_ADDR upward, up to DEPTH_WORDS words.
// Ports: clk_i, rst_i (async, active high), clear_i (sync restart);
//        req_valid_i/req_ready_o handshake with op_sel_i and field inputs;
//        imem_we_o/imem_addr_o/imem_data_o registered write port;
//        count_o words written, full_o capacity reached, err_o rejection pulse.
//
// state   | meaning
// IDLE    | ready for a request
// LI2     | emitting the ori half of an li
// FULL    | capacity reached, waiting for clear or reset
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  op_sel_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] imm_i,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_data_o,
    output logic [7:0]  count_o,
    output logic        full_o,
    output logic        err_o
);

    localparam logic [7:0] DEPTH_CNT = 8'(DEPTH_WORDS);
    localparam logic [7:0] LAST_SLOT = 8'(DEPTH_WORDS - 1);

    enc_state_e  state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [4:0]  li_rt_q, li_rt_d;
    logic [15:0] li_lo_q, li_lo_d;

    logic        in_li2;
    logic        accept;
    logic        is_li;
    logic [3:0]  pk_op_sel;
    logic [4:0]  pk_rt;
    logic [31:0] pk_imm;
    logic [31:0] pk_word;
    logic        pk_illegal;

    // In LI2 the packer is fed the fields captured with the li request
    assign in_li2    = (state_q == ST_LI2);
    assign pk_op_sel = in_li2 ? 4'(SEL_LI) : op_sel_i;
    assign pk_rt     = in_li2 ? li_rt_q : rt_i;
    assign pk_imm    = in_li2 ? {16'h0000, li_lo_q} : imm_i;

    instr_word_pack u_pack (
        .op_sel_i   (pk_op_sel),
        .rs_i       (rs_i),
        .rt_i       (pk_rt),
        .rd_i       (rd_i),
        .shamt_i    (shamt_i),
        .funct_i    (funct_i),
        .imm_i      (pk_imm),
        .li_phase_i (in_li2),
        .word_o     (pk_word),
        .illegal_o  (pk_illegal)
    );

    assign req_ready_o = (state_q == ST_IDLE);
    assign accept      = req_valid_i && req_ready_o && !clear_i;
    assign is_li       = (op_sel_i == 4'(SEL_LI));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        li_rt_d = li_rt_q;
        li_lo_d = li_lo_q;

        if (clear_i) begin
            state_d = ST_IDLE;
            ptr_d   = BASE_ADDR;
            waddr_d = BASE_ADDR;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        // li needs two free slots; with one left it is refused whole
                        if (pk_illegal || (is_li && cnt_q == LAST_SLOT)) begin
                            err_d = 1'b1;
                        end else begin
                            we_d    = 1'b1;
                            data_d  = pk_word;
                            waddr_d = ptr_q;
                            ptr_d   = ptr_q + 32'd4;
                            cnt_d   = cnt_q + 8'd1;
                            if (is_li) begin
                                state_d = ST_LI2;
                                li_rt_d = rt_i;
                                li_lo_d = imm_i[15:0];
                            end else if (cnt_q == LAST_SLOT) begin
                                state_d = ST_FULL;
                            end
                        end
                    end
                end
                ST_LI2: begin
                    we_d    = 1'b1;
                    data_d  = pk_word;
                    waddr_d = ptr_q;
                    ptr_d   = ptr_q + 32'd4;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = (cnt_q == LAST_SLOT) ? ST_FULL : ST_IDLE;
                end
                default: state_d = ST_FULL;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= BASE_ADDR;
            waddr_q <= BASE_ADDR;
            data_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            li_rt_q <= '0;
            li_lo_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            li_rt_q <= li_rt_d;
            li_lo_q <= li_lo_d;
        end
    end

    assign imem_we_o   = we_q;
    assign imem_addr_o = waddr_q;
    assign imem_data_o = data_q;
    assign count_o     = cnt_q;
    assign full_o      = (cnt_q == DEPTH_CNT);
    assign err_o       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        valid;
    logic        ready;
    logic [3:0]  op_sel;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  count;
    logic        full;
    logic        err;

    int checks   = 0;
    int failures = 0;

    instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(128)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .req_valid_i (valid),
        .req_ready_o (ready),
        .op_sel_i    (op_sel),
        .rs_i        (rs),
        .rt_i        (rt),
        .rd_i        (rd),
        .shamt_i     (shamt),
        .funct_i     (funct),
        .imm_i       (imm),
        .imem_we_o   (we),
        .imem_addr_o (addr),
        .imem_data_o (data),
        .count_o     (count),
        .full_o      (full),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [3:0] sel, input logic [4:0] s, input logic [4:0] t,
                       input logic [31:0] im);
        valid  = 1'b1;
        op_sel = sel;
        rs     = s;
        rt     = t;
        imm    = im;
        cycle();
        valid  = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            valid  = 1'b1;
            op_sel = SEL_ADDI;
            rs     = 5'd0;
            rt     = 5'd1;
            imm    = 32'(i);
            cycle();
            chk("fill_we", 32'(we), 32'd1);
        end
        valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; valid = 1'b0;
        op_sel = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we",    32'(we),    32'd0);
        chk("rst_addr",  addr,       32'h0);
        chk("rst_data",  data,       32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_err",   32'(err),   32'd0);

        // addi rs=0 rt=1 imm=5
        req(SEL_ADDI, 5'd0, 5'd1, 32'd5);
        chk("addi_we",    32'(we),    32'd1);
        chk("addi_addr",  addr,       32'h0);
        chk("addi_data",  data,       32'h2001_0005);
        chk("addi_count", 32'(count), 32'd1);

        // R-type add $3,$1,$2
        rd = 5'd3; shamt = 5'd0; funct = 6'h20;
        req(SEL_R, 5'd1, 5'd2, 32'd0);
        chk("r_data",  data, 32'h0022_1820);
        chk("r_addr",  addr, 32'h4);

        // li $4, 0x12345678
        req(SEL_LI, 5'd0, 5'd4, 32'h1234_5678);
        chk("li1_we",    32'(we),    32'd1);
        chk("li1_data",  data,       32'h3C04_1234);
        chk("li1_addr",  addr,       32'h8);
        chk("li1_ready", 32'(ready), 32'd0);
        chk("li1_count", 32'(count), 32'd3);
        cycle();
        chk("li2_we",    32'(we),    32'd1);
        chk("li2_data",  data,       32'h3484_5678);
        chk("li2_addr",  addr,       32'hC);
        chk("li2_count", 32'(count), 32'd4);
        chk("li2_ready", 32'(ready), 32'd1);
        cycle();
        chk("idle_we",   32'(we),    32'd0);
        chk("hold_data", data,       32'h3484_5678);

        // j 0x10
        req(SEL_J, 5'd0, 5'd0, 32'h0000_0010);
        chk("j_data", data, 32'h0800_0010);
        chk("j_addr", addr, 32'h10);

        // illegal op_sel 15
        req(4'd15, 5'd0, 5'd0, 32'd0);
        chk("ill_err",   32'(err),   32'd1);
        chk("ill_we",    32'(we),    32'd0);
        chk("ill_count", 32'(count), 32'd5);
        chk("ill_addr",  addr,       32'h10);
        cycle();
        chk("ill_err_pulse", 32'(err), 32'd0);

        // blez forces rt=0, lui forces rs=0, jal uses imm[25:0], sw
        req(SEL_BLEZ, 5'd2, 5'd7, 32'h0000_FFFC);
        chk("blez_data", data, 32'h1840_FFFC);
        chk("blez_addr", addr, 32'h14);
        req(SEL_LUI, 5'd3, 5'd2, 32'h0000_ABCD);
        chk("lui_data", data, 32'h3C02_ABCD);
        req(SEL_JAL, 5'd0, 5'd0, 32'hFFFF_FFFF);
        chk("jal_data", data, 32'h0FFF_FFFF);
        req(SEL_SW, 5'd29, 5'd31, 32'h0000_0008);
        chk("sw_data",  data,       32'hAFBF_0008);
        chk("sw_addr",  addr,       32'h20);
        chk("sw_count", 32'(count), 32'd9);

        // clear and fill to capacity back to back
        do_clear();
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_addr",  addr,       32'h0);
        chk("clr_ready", 32'(ready), 32'd1);
        fill(128);
        chk("full_addr",  addr,       32'h1FC);
        chk("full_data",  data,       32'h2001_007F);
        chk("full_count", 32'(count), 32'd128);
        chk("full_full",  32'(full),  32'd1);
        chk("full_ready", 32'(ready), 32'd0);
        req(SEL_ADDI, 5'd0, 5'd1, 32'd9);
        chk("full_nowe",   32'(we),    32'd0);
        chk("full_noerr",  32'(err),   32'd0);
        chk("full_count2", 32'(count), 32'd128);

        // clear wins over a simultaneous request
        clear = 1'b1; valid = 1'b1; op_sel = SEL_ADDI;
        cycle();
        clear = 1'b0; valid = 1'b0;
        chk("clrreq_we",    32'(we),    32'd0);
        chk("clrreq_count", 32'(count), 32'd0);
        chk("clrreq_addr",  addr,       32'h0);
        chk("clrreq_ready", 32'(ready), 32'd1);
        chk("clrreq_full",  32'(full),  32'd0);

        // li with one slot left is rejected
        fill(127);
        chk("s127_count", 32'(count), 32'd127);
        chk("s127_ready", 32'(ready), 32'd1);
        req(SEL_LI, 5'd0, 5'd4, 32'h1234_5678);
        chk("lirej_err",   32'(err),   32'd1);
        chk("lirej_we",    32'(we),    32'd0);
        chk("lirej_count", 32'(count), 32'd127);
        chk("lirej_addr",  addr,       32'h1F8);

        // li with two slots left fills the memory
        do_clear();
        fill(126);
        req(SEL_LI, 5'd0, 5'd4, 32'h1234_5678);
        chk("lifit1_addr",  addr,       32'h1F8);
        chk("lifit1_count", 32'(count), 32'd127);
        cycle();
        chk("lifit2_we",    32'(we),    32'd1);
        chk("lifit2_data",  data,       32'h3484_5678);
        chk("lifit2_addr",  addr,       32'h1FC);
        chk("lifit2_full",  32'(full),  32'd1);
        chk("lifit2_ready", 32'(ready), 32'd0);

        // clear during LI2 discards word 2
        do_clear();
        req(SEL_LI, 5'd0, 5'd6, 32'h0000_0001);
        chk("clrli_w1", data, 32'h3C06_0000);
        do_clear();
        chk("clrli_we",    32'(we),    32'd0);
        chk("clrli_count", 32'(count), 32'd0);
        chk("clrli_ready", 32'(ready), 32'd1);

        // async reset during LI2
        req(SEL_LI, 5'd0, 5'd5, 32'hDEAD_BEEF);
        chk("rstli_w1",    data,       32'h3C05_DEAD);
        chk("rstli_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rstli_we",    32'(we),    32'd0);
        chk("rstli_data",  data,       32'h0);
        chk("rstli_addr",  addr,       32'h0);
        chk("rstli_count", 32'(count), 32'd0);
        chk("rstli_ready", 32'(ready), 32'd1);
        cycle();
        rst = 1'b0;
        cycle();
        chk("rstli_nowe2",  32'(we),    32'd0);
        chk("rstli_count2", 32'(count), 32'd0);
        chk("rstli_data2",  data,       32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes control-level instruction requests (op class plus fields) into 32-bit MIPS words.
- Writes the words sequentially into instruction memory through a write port, using an auto-incrementing address.
- It is the producer counterpart of the CPU's opcode decoder; it is used by program loaders and testbenches to build programs.
- Supports the decoder's opcode set plus a `li` pseudo-op that expands into `lui` followed by `ori`.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word.
- DEPTH_WORDS, 128, capacity in words; the block refuses writes beyond it.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- clear_i  input  1  synchronous restart: address to BASE_ADDR, count to 0
- req_valid_i  input  1  request valid
- req_ready_o  output  1  encoder can accept a request
- op_sel_i  input  4  0 R, 1 addi, 2 beq, 3 bne, 4 lui, 5 ori, 6 sltiu, 7 j, 8 jal, 9 blez, 10 bgtz, 11 lw, 12 sw, 13 li, 14–15 illegal
- rs_i, rt_i, rd_i, shamt_i  input  5 each  register and shift fields
- funct_i  input  6  R-type function code
- imm_i  input  32  immediate; bits [15:0] for I-type, [25:0] for J-type, [31:0] for li
- imem_we_o  output  1  one-cycle write strobe
- imem_addr_o  output  32  byte address of the word
- imem_data_o  output  32  encoded word
- count_o  output  8  words written since reset or clear
- full_o  output  1  count_o == DEPTH_WORDS
- err_o  output  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset values: req_ready_o=1 (IDLE), imem_we_o=0, imem_addr_o=BASE_ADDR, imem_data_o=0, count_o=0, full_o=0, err_o=0.
- A request is accepted when req_valid_i && req_ready_o on a rising edge.
- Opcodes used: R 000000, addi 001000, beq 000100, bne 000101, lui 001111, ori 001101, sltiu 001011, j 000010, jal 000011, blez 000110, bgtz 000111, lw 100011, sw 101011.
- Encoding rules:
  - R: {000000, rs, rt, rd, shamt, funct}.
  - I-type: {op, rs, rt, imm[15:0]}.
  - lui: rs forced to 0.
  - blez and bgtz: rt forced to 0.
  - j and jal: {op, imm[25:0]}.
  - li: word 1 is lui rt, imm[31:16] (rs=0); word 2 is ori rt, rt, imm[15:0].
- States:
  - IDLE: ready=1. On an accepted legal single-word op, emit the word and stay in IDLE. On accepted li, emit word 1 and go to LI2.
  - LI2: ready=0. Emit word 2, then go to IDLE, or to FULL if capacity is reached.
  - FULL: ready=0, full_o=1. Leaves only on clear_i or reset.
- Latency: imem_we_o, imem_addr_o and imem_data_o are registered and valid the cycle after acceptance. For li, the two words appear on consecutive cycles.
- The address in imem_addr_o is the current word pointer. After each write the pointer advances by 4 and count_o increments.
- imem_data_o holds its last value when imem_we_o=0.
- Rejection: an illegal op_sel_i, or li when only one slot remains, produces err_o for one cycle. There is no write, count_o and the address are unchanged, and the state stays IDLE.
- Back-to-back single-word requests sustain one write per cycle.
- Reaching count DEPTH_WORDS: the transition to FULL happens with the final write. req_ready_o drops the cycle after that write, so no request is accepted in FULL.
- clear_i has priority over any request in the same cycle: the request is not accepted, and the block returns to IDLE with address and count reset. If clear_i arrives in LI2, word 2 is discarded.
- rst_i mid-operation, including in LI2, returns everything asynchronously to the reset values. No partial write is produced afterwards.

Decomposition:
- Shared package (e.g. mips_isa_pkg) holds:
  - the 6-bit opcode constants listed above, also used by the decoder;
  - the op_sel encoding;
  - the field bit positions.
- One natural sub-module, instr_word_pack: combinational packing of (op_sel, fields, li phase) into a 32-bit word plus an illegal flag.
- The instr_encoder top level holds the FSM, address pointer and counter.

Test Plan:
1. After reset, addi rs=0 rt=1 imm=5 → next cycle we=1, addr=0x0, data=0x20010005, count_o=1.
2. R op, rs=1 rt=2 rd=3 shamt=0 funct=0x20 → data=0x00221820 at addr 0x4.
3. li rt=4 imm=0x12345678 → data 0x3C041234 then 0x34845678 on consecutive cycles. ready=0 during LI2; count rises by 2.
4. j imm=0x10 → data=0x08000010. Then op_sel=15 → err_o pulse, no we, addr and count unchanged.
5. Issue DEPTH_WORDS single-word requests back to back → last addr=BASE+4·(DEPTH−1), full_o=1, ready=0. A further valid request produces no write. clear_i → addr=BASE, count=0, ready=1.
6. With DEPTH−1 words written, li → err_o, no write. Separately, assert rst_i during LI2 → no second word, all outputs at reset values.
